// File: rtl/mp_add_seq_if.sv
// Request/result handshake bundle for the chunk-serial adder/subtractor.
// The master side issues operands and consumes results; the slave side is the adder.
interface mp_add_seq_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         c_out;
   logic         ovf;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, result, c_out, ovf
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, result, c_out, ovf
   );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one N-bit carry-lookahead slice reused over WORDS
// chunks, LSB first, one chunk per clock; subtraction is A + ~B + 1.
module mp_add_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   mp_add_seq_if.slave  bus
);
   localparam int W  = N * WORDS;
   localparam int CW = ($clog2(WORDS) > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] cnt_r;
   logic          carry_r;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic [W-1:0]  result_r;
   logic          c_out_r;
   logic          ovf_r;

   logic [N-1:0]  a_chunk_s;
   logic [N-1:0]  b_chunk_s;
   logic [N-1:0]  sum_s;
   logic          cout_s;
   logic          ovf_s;
   logic          accept_s;
   logic          step_s;
   logic          last_s;

   // Each carry is the full generate/propagate prefix expansion, not a ripple chain.
   function automatic logic [N:0] cla_slice(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic         cin);
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N:0]   c;
      logic         pp;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         c[i+1] = g[i];
         pp     = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp     = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & cin);
      end
      return {c[N], p ^ c[N-1:0]};
   endfunction

   // Chunk selection and slice evaluation for the current counter position.
   always_comb begin
      a_chunk_s         = a_r[cnt_r*N +: N];
      b_chunk_s         = b_r[cnt_r*N +: N];
      {cout_s, sum_s}   = cla_slice(a_chunk_s, b_chunk_s, carry_r);
      ovf_s             = (a_r[W-1] == b_r[W-1]) && (sum_s[N-1] != a_r[W-1]);
   end

   // Next-state decode; clear overrides every other request.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      step_s   = 1'b0;
      last_s   = 1'b0;
      if (clear) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  accept_s = 1'b1;
                  state_s  = RUN;
               end else begin
                  state_s  = IDLE;
               end
            end
            RUN: begin
               step_s = 1'b1;
               if (cnt_r == LAST_CNT) begin
                  last_s  = 1'b1;
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_s = IDLE;
               end else begin
                  state_s = DONE;
               end
            end
            default: state_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture, per-chunk accumulation and final flag capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         carry_r  <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         result_r <= '0;
         c_out_r  <= 1'b0;
         ovf_r    <= 1'b0;
      end else if (accept_s) begin
         a_r     <= bus.op_a;
         b_r     <= bus.sub ? ~bus.op_b : bus.op_b;
         carry_r <= bus.sub;
         cnt_r   <= '0;
      end else if (step_s) begin
         result_r[cnt_r*N +: N] <= sum_s;
         carry_r                <= cout_s;
         if (last_s) begin
            c_out_r <= cout_s;
            ovf_r   <= ovf_s;
         end else begin
            cnt_r   <= cnt_r + 1'b1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.in_ready  = (state_r == IDLE);
   assign bus.out_valid = (state_r == DONE);
   assign bus.result    = result_r;
   assign bus.c_out     = c_out_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_mp_add_seq.sv
// Randomised self-checking bench for mp_add_seq (N=4, WORDS=4) against an
// integer-arithmetic reference of add/subtract with carry and signed overflow.
module tb_mp_add_seq;
   logic clk;
   logic rst_n;
   logic clear;
   int   checks_n;
   int   fails_n;

   mp_add_seq_if #(.W(16)) bus ();

   mp_add_seq #(.N(4), .WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_n++;
      if (obs !== exp) begin
         fails_n++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Returns {c_out, ovf, result[15:0]} from plain integer arithmetic.
   function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
      int   ua, ub, sa, sb, ur, sr;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (s) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur > 65535);
      end
      v = (sr > 32767) || (sr < -32768);
      return {c, v, ur[15:0]};
   endfunction

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int hold);
      logic [17:0] exp;
      int          cyc;
      exp = ref_op(a, b, s);
      check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.sub      = s;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("accepted", 32'(bus.in_ready), 32'd0);
      // Keep in_valid high with junk operands while busy: must not be re-sampled.
      bus.op_a = 16'($urandom);
      bus.op_b = 16'($urandom);
      bus.sub  = 1'($urandom);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("latency", 32'(cyc), 32'd4);
      check_eq("result", 32'(bus.result), 32'(exp[15:0]));
      check_eq("c_out", 32'(bus.c_out), 32'(exp[17]));
      check_eq("ovf", 32'(bus.ovf), 32'(exp[16]));
      for (int k = 0; k < hold; k++) begin
         bus.in_valid = ((k % 2) == 0);
         @(posedge clk); #1;
         check_eq("hold_result", 32'(bus.result), 32'(exp[15:0]));
         check_eq("hold_busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_eq("release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
   endtask

   initial begin
      checks_n      = 0;
      fails_n       = 0;
      rst_n         = 1'b0;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op_a      = 16'h0000;
      bus.op_b      = 16'h0000;
      bus.sub       = 1'b0;
      #2;
      check_eq("rst_state", {28'd0, bus.in_ready, bus.out_valid, bus.c_out, bus.ovf}, 32'd8);
      check_eq("rst_result", 32'(bus.result), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_op(16'h1234, 16'h0FCD, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 0);
      do_op(16'h1234, 16'h0FCD, 1'b0, 3);

      // Abort with clear two chunks into an add; a simultaneous in_valid must lose.
      bus.op_a     = 16'h1234;
      bus.op_b     = 16'h0FCD;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("clr_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check_eq("clr_no_valid", 32'(bus.out_valid), 32'd0);
      end
      do_op(16'h0001, 16'h0001, 1'b0, 0);

      // Asynchronous reset mid-RUN.
      bus.op_a     = 16'hAAAA;
      bus.op_b     = 16'h5555;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_state", {28'd0, bus.in_ready, bus.out_valid, bus.c_out, bus.ovf}, 32'd8);
      check_eq("arst_result", 32'(bus.result), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(16'h8000, 16'h0001, 1'b1, 0);

      for (int n = 0; n < 40; n++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
      $finish;
   end
endmodule
